// File: rtl/hex_display_bank.sv
// Registered seven-segment controller for a bank of HEX digits: glyph store with
// random-access write and scroll, active-low decode, and per-digit blinking.
module hex_display_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 3,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [4:0]              wr_data,
  input  logic                    shift_en,
  input  logic [4:0]              shift_data,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    blink_phase
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [4:0] BLANK = 5'd31;

  logic [4:0]              r_glyph [NUM_DIGITS];
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_phase;
  logic [7*NUM_DIGITS-1:0] r_segs;
  logic [7*NUM_DIGITS-1:0] w_segs;

  // Active-low patterns, bit order g..a.
  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'b1111001;
      5'd1:    decode = 7'b0100100;
      5'd2:    decode = 7'b0110000;
      5'd3:    decode = 7'b0011001;
      5'd4:    decode = 7'b0010010;
      5'd5:    decode = 7'b0000010;
      5'd6:    decode = 7'b1111000;
      5'd7:    decode = 7'b0000000;
      5'd8:    decode = 7'b0001000;
      5'd9:    decode = 7'b0000011;
      5'd10:   decode = 7'b1000110;
      5'd11:   decode = 7'b0100001;
      5'd12:   decode = 7'b0000110;
      5'd13:   decode = 7'b0001110;
      5'd14:   decode = 7'b0010000;
      5'd15:   decode = 7'b0001001;
      5'd16:   decode = 7'b1001111;
      5'd17:   decode = 7'b1000111;
      5'd18:   decode = 7'b0001100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Clear beats shift beats write; out-of-range write addresses match no digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_glyph[i] <= BLANK;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_glyph[i] <= BLANK;
    end else if (shift_en) begin
      for (int i = 1; i < NUM_DIGITS; i++) r_glyph[i] <= r_glyph[i-1];
      r_glyph[0] <= shift_data;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == ADDR_W'(i)) r_glyph[i] <= wr_data;
      end
    end
  end

  // Free-running blink prescaler; deliberately unaffected by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_segs = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_segs[7*i +: 7] = (r_phase & blink_mask[i]) ? 7'b1111111 : decode(r_glyph[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_segs <= '1;
    else        r_segs <= w_segs;
  end

  assign segs        = r_segs;
  assign blink_phase = r_phase;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank with a short blink period so that
// blinking and the async reset path can be observed in a few cycles.
module tb_hex_display_bank;

  localparam int ND = 6;
  localparam int AW = 3;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SG = 7'b0010000;
  localparam logic [6:0] SH = 7'b0001001;
  localparam logic [6:0] SI = 7'b1001111;
  localparam logic [6:0] SL = 7'b1000111;
  localparam logic [6:0] SP = 7'b0001100;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [4:0]    wr_data;
  logic          shift_en;
  logic [4:0]    shift_data;
  logic [ND-1:0] blink_mask;
  logic [7*ND-1:0] segs;
  logic          blink_phase;

  int n_tests = 0;
  int n_fail  = 0;

  hex_display_bank #(.NUM_DIGITS(ND), .ADDR_W(AW), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .shift_en(shift_en), .shift_data(shift_data),
    .blink_mask(blink_mask), .segs(segs), .blink_phase(blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] pk(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-derived blink schedule for edges 1..12 after reset release (bit k-1 = edge k).
  logic [11:0] exp_phase = 12'b1000_0111_1000;
  // Digit 1 dark after edge k (bit k-1), glyph valid from edge 2 on.
  logic [11:0] exp_dark  = 12'b0000_1111_0000;

  initial begin
    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    shift_en = 1'b0; shift_data = '0; blink_mask = '0;

    // Reset
    tick(); tick(); tick();
    chk("reset_segs", segs, {42{1'b1}});
    chk("reset_phase", {41'd0, blink_phase}, 42'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_segs", segs, {42{1'b1}});

    // Random write and its two-edge latency
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'd8;
    tick();
    wr_en = 1'b0;
    chk("write_latency", segs, {42{1'b1}});
    tick();
    chk("write_addr2", segs, pk(BL, BL, BL, SA, BL, BL));
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 5'd0;
    tick();
    wr_en = 1'b0;
    tick();
    chk("write_oob", segs, pk(BL, BL, BL, SA, BL, BL));

    // Scroll, back-to-back
    shift_en = 1'b1;
    shift_data = 5'd18; tick();
    shift_data = 5'd17; tick();
    shift_data = 5'd16; tick();
    shift_data = 5'd15; tick();
    shift_data = 5'd14; tick();
    shift_data = 5'd13; tick();
    shift_en = 1'b0;
    tick();
    chk("scroll6", segs, pk(SP, SL, SI, SH, SG, SF));
    shift_en = 1'b1; shift_data = 5'd31;
    tick();
    shift_en = 1'b0;
    tick();
    chk("scroll7", segs, pk(SL, SI, SH, SG, SF, BL));

    // Priority: shift beats write, clear beats shift
    shift_en = 1'b1; shift_data = 5'd0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'd5;
    tick();
    shift_en = 1'b0; wr_en = 1'b0;
    tick();
    chk("shift_over_write", segs, pk(SI, SH, SG, SF, BL, S1));
    clear = 1'b1; shift_en = 1'b1; shift_data = 5'd8;
    tick();
    clear = 1'b0; shift_en = 1'b0;
    tick();
    chk("clear_over_shift", segs, {42{1'b1}});

    // Blink with a fresh prescaler
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'd12; blink_mask = 6'b000010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      wr_en = 1'b0;
      chk($sformatf("blink_phase_e%0d", k), {41'd0, blink_phase}, {41'd0, exp_phase[k-1]});
      if (k >= 2)
        chk($sformatf("blink_segs_e%0d", k), segs,
            pk(BL, BL, BL, BL, exp_dark[k-1] ? BL : SE, BL));
    end
    blink_mask = 6'b000000;
    tick();
    chk("mask_off_phase", {41'd0, blink_phase}, 42'd1);
    chk("mask_off_segs", segs, pk(BL, BL, BL, BL, SE, BL));

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #2;
    chk("async_phase", {41'd0, blink_phase}, 42'd0);
    chk("async_segs", segs, {42{1'b1}});
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_bank.md
# hex_display_bank

Registered, multi-digit seven-segment display controller for the DE10-Lite HEX bank. Holds one 5-bit glyph code per digit and accepts random-access writes and right-to-left scroll shifts. Decodes each glyph to active-low segments and applies per-digit blinking from an internal prescaler. It sits between the game logic (move entry, coordinate and status text) and the HEX0..HEX5 pins, and replaces per-digit combinational decoders.

## Interface
Parameters:
- NUM_DIGITS, 6: number of digits driven; digit 0 = rightmost (HEX0).
- ADDR_W, 3: width of wr_addr; must satisfy 2^ADDR_W >= NUM_DIGITS.
- BLINK_DIV, 25000000: clock cycles per blink half-period (0.5 s at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  blank all digits.
- wr_en  in  1  write wr_data into digit wr_addr.
- wr_addr  in  ADDR_W  target digit index.
- wr_data  in  5  glyph code.
- shift_en  in  1  scroll left: shift_data enters digit 0.
- shift_data  in  5  glyph code entering on shift.
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks.
- segs  out  7*NUM_DIGITS  active-low segments; bits [7i+6:7i] = digit i, bit order g..a (bit 0 = a).
- blink_phase  out  1  current blink phase; 1 = blinking digits are dark.

## Operation
- Glyph codes: 0-7 → digits '1'..'8'; 8 A, 9 b, 10 C, 11 d, 12 E, 13 F, 14 g, 15 H, 16 I, 17 L, 18 P; 19-31 → blank (7'b1111111).
- Segment patterns (g..a): 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110, g 0010000, H 0001001, I 1001111, L 1000111, P 0001100.
- Glyph store: NUM_DIGITS × 5-bit registers. The blank code is 5'd31.
- Per-edge update priority: clear > shift_en > wr_en.
  - clear: all glyphs set to 31.
  - shift_en: glyph[i] ← glyph[i-1] for i ≥ 1, and glyph[0] ← shift_data. A concurrent write is dropped.
  - wr_en: glyph[wr_addr] ← wr_data. If wr_addr ≥ NUM_DIGITS, nothing changes.
- Blink prescaler: counter runs 0..BLINK_DIV-1. On the edge where the counter is at BLINK_DIV-1, it wraps to 0 and blink_phase toggles. The counter is free-running and not affected by clear.
- Output: segs register per digit i = 7'b1111111 if (blink_phase & blink_mask[i]), else decode(glyph[i]).

## Timing
- Reset (asynchronous assert, released synchronously to clk externally): glyphs all 31, segs all 1s, counter 0, blink_phase 0.
- Write/shift/clear latency: the command is sampled at edge N, the glyph register updates at N, and segs reflects it after edge N+1 (2-cycle pipe from input to pins).
- blink_mask is sampled each cycle. A change at edge N is visible on segs after edge N.
- blink_phase toggles every BLINK_DIV cycles; the first toggle is at the BLINK_DIV-th edge after reset release. segs follows one edge later.
- Consecutive shift_en pulses on back-to-back cycles shift once per cycle, with no bubbles.
- Reset mid-operation: everything returns to reset values immediately, independent of clk.

## Test plan
- Reset: hold rst_n=0, toggle clk → segs = all 1s, blink_phase = 0. Release reset, idle 3 cycles → segs unchanged.
- Random write: wr_en, addr 2, data 8 → two edges later segs[20:14] = 0001000 ('A'), all other digits 1111111. Then write addr 7 (NUM_DIGITS=6) → segs unchanged.
- Scroll: six consecutive shift_en with data 18,17,16,15,14,13 → segs digits 5..0 = P,L,I,H,g,F. A seventh shift of 31 → digit 5 = L, digit 0 blank.
- Priority: the same cycle asserts shift_en (data 0) and wr_en (addr 0, data 5) → digit 0 = '1' (0x79 pattern 1111001), write dropped. clear + shift together → all blank.
- Blink (BLINK_DIV=4): glyph[1]=12 ('E'), blink_mask=6'b000010 → blink_phase toggles every 4 cycles, and digit 1 alternates between 0000110 and 1111111 with a one-cycle lag. Digit 1 with its mask bit 0 stays 0000110.
- Async reset mid-blink: assert rst_n=0 between edges while blink_phase=1 → blink_phase and segs clear without waiting for a clock edge.
